// File: rtl/sdram_port_scheduler_pkg.sv
// Shared constants for the SDRAM port scheduler: memory bank codes, FSM state
// encoding and a small index-width helper.
package sdram_port_scheduler_pkg;

    localparam logic [3:0] BANK_INVALID = 4'd0;
    localparam logic [3:0] BANK_SDRAM   = 4'd1;
    localparam logic [3:0] BANK_CART    = 4'd2;
    localparam logic [3:0] BANK_SRAM    = 4'd3;
    localparam logic [3:0] BANK_FLASH   = 4'd4;

    localparam logic [1:0] STATE_IDLE     = 2'd0;
    localparam logic [1:0] STATE_ISSUE    = 2'd1;
    localparam logic [1:0] STATE_WAIT_ACK = 2'd2;

    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/sdram_port_scheduler_picker.sv
// Combinational winner selection: a starved (saturated) valid master beats
// plain priority; within either group the lowest index wins.
module starvation_priority_picker
    import sdram_port_scheduler_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 3,
    parameter int IDX_W           = index_width(NUM_CONTROLLERS)
) (
    input  logic [NUM_CONTROLLERS-1:0] valid,
    input  logic [NUM_CONTROLLERS-1:0] saturated,
    output logic [NUM_CONTROLLERS-1:0] grant,
    output logic [IDX_W-1:0]           index
);

    logic [NUM_CONTROLLERS-1:0] starved;
    logic [NUM_CONTROLLERS-1:0] pool;

    assign starved = valid & saturated;
    assign pool    = (|starved) ? starved : valid;

    // Scan downwards so the last hit, the lowest index, is the one kept.
    always_comb begin
        grant = '0;
        index = '0;
        for (int i = NUM_CONTROLLERS - 1; i >= 0; i--) begin
            if (pool[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                index    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares one SDRAM device port between several bus masters: fixed priority with
// a bounded-wait override, one device transaction in flight at a time.
module sdram_port_scheduler
    import sdram_port_scheduler_pkg::*;
#(
    parameter int         NUM_CONTROLLERS = 3,
    parameter int         ADDRESS_WIDTH   = 25,
    parameter logic [3:0] DEVICE_BANK     = BANK_SDRAM,
    parameter int         MAX_WAIT        = 15
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,
    input  logic [NUM_CONTROLLERS-1:0]           i_request,
    input  logic [NUM_CONTROLLERS-1:0]           i_write,
    input  logic [4*NUM_CONTROLLERS-1:0]         i_bank,
    input  logic [ADDRESS_WIDTH*NUM_CONTROLLERS-1:0] i_address,
    input  logic [32*NUM_CONTROLLERS-1:0]        i_data,
    output logic [NUM_CONTROLLERS-1:0]           o_busy,
    output logic [NUM_CONTROLLERS-1:0]           o_ack,
    output logic [32*NUM_CONTROLLERS-1:0]        o_data,
    output logic                                 o_device_request,
    output logic                                 o_device_write,
    input  logic                                 i_device_busy,
    input  logic                                 i_device_ack,
    output logic [ADDRESS_WIDTH-1:0]             o_device_address,
    input  logic [31:0]                          i_device_data,
    output logic [31:0]                          o_device_data
);

    localparam int               IDX_W      = index_width(NUM_CONTROLLERS);
    localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [1:0]                 state;
    logic [IDX_W-1:0]           grant;
    logic [CNT_W-1:0]           wait_count [NUM_CONTROLLERS];
    logic [NUM_CONTROLLERS-1:0] valid;
    logic [NUM_CONTROLLERS-1:0] saturated;
    logic [NUM_CONTROLLERS-1:0] owned;
    logic [NUM_CONTROLLERS-1:0] pick_onehot;
    logic [IDX_W-1:0]           pick_index;
    logic                       start;
    logic                       accept;

    always_comb begin
        valid     = '0;
        saturated = '0;
        owned     = '0;
        for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            valid[k]     = i_request[k] && (i_bank[4*k +: 4] == DEVICE_BANK);
            saturated[k] = (wait_count[k] == WAIT_LIMIT);
            owned[k]     = (state != STATE_IDLE) && (grant == IDX_W'(k));
        end
    end

    assign start  = (state == STATE_IDLE) && (|valid);
    assign accept = (state == STATE_ISSUE) && !i_device_busy;

    // Busy drops only for the owner in the single cycle the device takes the request.
    always_comb begin
        o_busy = '0;
        for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            o_busy[k] = valid[k] && !(accept && (grant == IDX_W'(k)));
        end
    end

    starvation_priority_picker #(
        .NUM_CONTROLLERS(NUM_CONTROLLERS),
        .IDX_W          (IDX_W)
    ) picker (
        .valid    (valid),
        .saturated(saturated),
        .grant    (pick_onehot),
        .index    (pick_index)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                wait_count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                if (!valid[k] || (start && pick_onehot[k])) begin
                    wait_count[k] <= '0;
                end else if (!owned[k] && (wait_count[k] != WAIT_LIMIT)) begin
                    wait_count[k] <= wait_count[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= STATE_IDLE;
            grant            <= '0;
            o_device_request <= 1'b0;
            o_device_write   <= 1'b0;
            o_device_address <= '0;
            o_device_data    <= '0;
            o_ack            <= '0;
            o_data           <= '0;
        end else begin
            o_ack <= '0;
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        state            <= STATE_ISSUE;
                        grant            <= pick_index;
                        o_device_request <= 1'b1;
                        o_device_write   <= i_write[pick_index];
                        o_device_address <= i_address[pick_index*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        o_device_data    <= i_data[pick_index*32 +: 32];
                    end
                end
                STATE_ISSUE: begin
                    if (!i_device_busy) begin
                        state            <= STATE_WAIT_ACK;
                        o_device_request <= 1'b0;
                    end
                end
                STATE_WAIT_ACK: begin
                    if (i_device_ack) begin
                        state                  <= STATE_IDLE;
                        o_ack[grant]           <= 1'b1;
                        o_data[grant*32 +: 32] <= i_device_data;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sdram_port_scheduler.md
# sdram_port_scheduler

Shares one memory device port between up to NUM_CONTROLLERS bus masters (N64 PI, PC USB, SD DMA). It implements fixed priority with a bounded-wait anti-starvation override, and allows exactly one device transaction in flight. It sits between the masters' request/busy/ack buses and the SDRAM controller. It also returns read data and completion acks to the owning master.

## Interface
- NUM_CONTROLLERS, 3, number of masters; index 0 has the highest base priority.
- ADDRESS_WIDTH, 25, device word-address width.
- DEVICE_BANK, 4'd1, bank code this port serves.
- MAX_WAIT, 15, cycles a pending master may wait before it is force-granted (≥1).
- i_clk  in  1  system clock; single clock domain.
- i_reset_n  in  1  reset, asynchronous assert, active low.
- i_request  in  NUM_CONTROLLERS  per-master request; held until accepted.
- i_write  in  NUM_CONTROLLERS  per-master write flag.
- i_bank  in  4*NUM_CONTROLLERS  per-master bank, flattened; master k uses [4k+3:4k].
- i_address  in  ADDRESS_WIDTH*NUM_CONTROLLERS  per-master address, flattened.
- i_data  in  32*NUM_CONTROLLERS  per-master write data, flattened.
- o_busy  out  NUM_CONTROLLERS  master k is not accepted this cycle.
- o_ack  out  NUM_CONTROLLERS  one-cycle completion pulse for master k.
- o_data  out  32*NUM_CONTROLLERS  read data, valid with o_ack[k].
- o_device_request  out  1  device request.
- o_device_write  out  1  device write flag.
- i_device_busy  in  1  device not accepting.
- i_device_ack  in  1  device completion, with read data.
- o_device_address  out  ADDRESS_WIDTH  device address.
- i_device_data  in  32  device read data.
- o_device_data  out  32  device write data.

## Operation
- A master k is **valid** when i_request[k] && i_bank[k] == DEVICE_BANK. Requests to other banks are ignored: busy is 0 and the master is never granted.
- The FSM has three states: IDLE, ISSUE, WAIT_ACK.
- **IDLE**
  - If any master is valid, select a winner.
  - Winner selection: the lowest index whose wait counter == MAX_WAIT; otherwise the lowest valid index.
  - Register the grant index, write flag, address and data. Go to ISSUE.
- **ISSUE**
  - o_device_request = 1.
  - When !i_device_busy, the request is accepted. Go to WAIT_ACK.
- **WAIT_ACK**
  - o_device_request = 0.
  - On i_device_ack: register o_data[grant] = i_device_data, pulse o_ack[grant] for the next cycle, and go to IDLE.
- **o_busy[k]** = valid[k] && !(state == ISSUE && grant == k && !i_device_busy), computed combinationally.
  - The single low cycle is the accept cycle. The master deasserts i_request after it.
- **Wait counters**: one per master, width clog2(MAX_WAIT+1).
  - Increment each cycle master k is valid and not the current grant; saturate at MAX_WAIT.
  - Clear when granted (IDLE→ISSUE for k) or when not valid.
- o_data[k] holds its last value until the next ack to k.

## Timing
- Reset values: state IDLE; o_device_request 0, o_device_write 0, o_device_address 0, o_device_data 0; o_ack 0; o_data all 0; counters 0.
- Minimum latency:
  - request seen in IDLE at cycle t → o_device_request at t+1.
  - Accept possible at t+1; o_ack at (device ack cycle)+1.
- Back-to-back: after the ack cycle the FSM is in IDLE. The next grant is decided in that cycle, giving at most one idle device cycle between transactions.
- Device outputs are registered and stable for the whole ISSUE state.
- i_device_ack outside WAIT_ACK is ignored.
- Simultaneous valid masters with equal status: the lowest index wins.
- Multiple masters at MAX_WAIT: the lowest index among them wins. The others keep their saturated count.
- A master dropping its request before accept is a protocol violation. The transaction still completes and acks that master.
- Reset mid-transaction returns the FSM to IDLE immediately and raises no ack. The device is reset together with the scheduler.

## Structure
- Shared package constants: the BANK_* codes (DEVICE_BANK values) and the state encoding for IDLE/ISSUE/WAIT_ACK.
- One natural sub-module, `starvation_priority_picker`:
  - Inputs: valid vector and counter-saturated vector.
  - Outputs: one-hot grant and index; combinational.
- The FSM, counters and muxing stay in the top of this block.

## Test plan
- Single read: master 1 requests address 0x0001234, bank=DEVICE_BANK; device accepts immediately and acks 3 cycles later with 0xDEADBEEF → o_device_request for 1 cycle, o_busy[1] low 1 cycle, o_ack[1] one pulse with o_data[1]=0xDEADBEEF.
- Priority: masters 0 and 2 request in the same cycle → master 0 is served first; master 2 is served in the next transaction.
- Starvation: master 0 requests continuously, device ack latency 2, MAX_WAIT=15 → master 2 is granted no later than the transaction started after its counter reaches 15.
- Bank filter: master 1 requests with bank≠DEVICE_BANK → o_busy[1]=0, no device request, no ack.
- Device busy: i_device_busy held 5 cycles during ISSUE → o_device_request and address stay stable for 5 cycles; accept on cycle 6; write data 0xA5A5A5A5 is presented unchanged.
- Reset: assert i_reset_n=0 during WAIT_ACK → all outputs reach their reset values asynchronously; a later device ack produces no o_ack.
